// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture core: FSM state and trigger-mode encodings.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MOVE_TO_POS = 3'd1,
    ST_IN_POSITION = 3'd2,
    ST_CAPTURING   = 3'd3,
    ST_CAPTURED    = 3'd4
  } la_state_e;

  typedef enum logic [1:0] {
    TRIG_EQ      = 2'd0,
    TRIG_RISING  = 2'd1,
    TRIG_FALLING = 2'd2,
    TRIG_CHANGE  = 2'd3
  } la_trig_mode_e;

endpackage

// File: rtl/la_sample_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module la_sample_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage and read register deliberately have no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular pre-trigger buffer, masked trigger, post-trigger fill,
// and oldest-first readback through a rotated read address.
module la_capture_core
  import la_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLE_DEPTH = 256,
  parameter int TRIGGER_LOC  = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMPLE_WIDTH-1:0]         probes,
  input  logic                            arm,
  input  logic [SAMPLE_WIDTH-1:0]         trig_mask,
  input  logic [SAMPLE_WIDTH-1:0]         trig_value,
  input  logic [1:0]                      trig_mode,
  output logic [2:0]                      state,
  output logic                            done,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] rd_addr,
  output logic [SAMPLE_WIDTH-1:0]         rd_data
);

  localparam int AW   = $clog2(SAMPLE_DEPTH);
  localparam int POST = SAMPLE_DEPTH - TRIGGER_LOC;
  localparam logic [AW-1:0] LOC_A    = AW'(TRIGGER_LOC);
  localparam logic [AW-1:0] LOC_LAST = AW'((TRIGGER_LOC == 0) ? 0 : TRIGGER_LOC - 1);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(POST - 1);

  la_state_e               state_q;
  logic [SAMPLE_WIDTH-1:0] p_q, p_qq;
  logic [AW-1:0]           wr_ptr, pre_cnt, start_ptr;
  logic [AW:0]             post_cnt;
  logic                    trig_hit, wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0;
      p_qq <= '0;
    end else begin
      p_q  <= probes;
      p_qq <= p_q;
    end
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_EQ:      trig_hit = ((p_q ^ trig_value) & trig_mask) == '0;
      TRIG_RISING:  trig_hit = |(~p_qq & p_q & trig_mask);
      TRIG_FALLING: trig_hit = |(p_qq & ~p_q & trig_mask);
      default:      trig_hit = |((p_qq ^ p_q) & trig_mask);
    endcase
  end

  // With TRIGGER_LOC=0 the pre-fill phase writes nothing and only spends one cycle.
  assign wr_en = !arm &&
                 ((state_q == ST_MOVE_TO_POS && !(TRIGGER_LOC == 0)) ||
                  state_q == ST_IN_POSITION || state_q == ST_CAPTURING);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done      <= 1'b0;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      start_ptr <= '0;
    end else if (arm) begin
      state_q  <= ST_MOVE_TO_POS;
      done     <= 1'b0;
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case (state_q)
        ST_MOVE_TO_POS: begin
          if (pre_cnt == LOC_LAST) state_q <= ST_IN_POSITION;
          else                     pre_cnt <= pre_cnt + 1'b1;
        end
        ST_IN_POSITION: begin
          if (trig_hit) begin
            start_ptr <= wr_ptr - LOC_A;
            post_cnt  <= (AW+1)'(1);
            if (POST == 1) begin
              state_q <= ST_CAPTURED;
              done    <= 1'b1;
            end else begin
              state_q <= ST_CAPTURING;
            end
          end
        end
        ST_CAPTURING: begin
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == POST_LAST) begin
            state_q <= ST_CAPTURED;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

  la_sample_mem #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (SAMPLE_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (p_q),
    .raddr (start_ptr + rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per captured sample (concatenated probes, 1..64).
REQ-002 SHALL have parameter SAMPLE_DEPTH, default 256, samples stored; power of two, 4..4096.
REQ-003 SHALL have parameter TRIGGER_LOC, default 128, pre-trigger sample count; 0..SAMPLE_DEPTH-1.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port probes  in  SAMPLE_WIDTH  signals under observation, synchronous to clk.
REQ-007 SHALL have port arm  in  1  single-cycle pulse starting a capture.
REQ-008 SHALL have port trig_mask  in  SAMPLE_WIDTH  bits participating in the trigger.
REQ-009 SHALL have port trig_value  in  SAMPLE_WIDTH  compare value for EQ mode.
REQ-010 SHALL have port trig_mode  in  2  trigger mode: 0 EQ, 1 RISING, 2 FALLING, 3 CHANGE.
REQ-011 SHALL have port state  out  3  current FSM state encoding.
REQ-012 SHALL have port done  out  1  high while in CAPTURED.
REQ-013 SHALL have port rd_addr  in  log2(SAMPLE_DEPTH)  read index, 0 = oldest sample.
REQ-014 SHALL have port rd_data  out  SAMPLE_WIDTH  sample at rd_addr, one-cycle latency.

Function
REQ-015 SHALL register probes once (p_q) and hold the previous registered value (p_qq); all trigger and storage use p_q.
REQ-016 Trigger SHALL be: EQ ((p_q^trig_value)&mask)==0; RISING any masked bit 0->1 (p_qq to p_q); FALLING any masked 1->0; CHANGE any masked bit differs.
REQ-017 Mask all-zero SHALL make EQ fire immediately and edge modes never fire.
REQ-018 FSM states SHALL be IDLE(0), MOVE_TO_POS(1), IN_POSITION(2), CAPTURING(3), CAPTURED(4).
REQ-019 IDLE: no writes; arm -> MOVE_TO_POS, write pointer and pre-count cleared.
REQ-020 MOVE_TO_POS: write p_q every cycle, pointer increments; after TRIGGER_LOC writes -> IN_POSITION (TRIGGER_LOC=0 goes directly to IN_POSITION next cycle); triggers ignored here.
REQ-021 IN_POSITION: write every cycle, pointer wraps modulo SAMPLE_DEPTH (circular pre-trigger buffer); trigger -> CAPTURING, the triggering sample written at index TRIGGER_LOC.
REQ-022 CAPTURING: write until exactly SAMPLE_DEPTH-TRIGGER_LOC samples stored from trigger inclusive -> CAPTURED.
REQ-023 CAPTURED: no writes, buffer frozen until next arm.
REQ-024 arm in any non-IDLE state SHALL restart at MOVE_TO_POS, discarding the capture; arm has priority over trigger in same cycle.
REQ-025 On trigger SHALL latch start_ptr = trigger write address - TRIGGER_LOC (mod SAMPLE_DEPTH).
REQ-026 Read SHALL access memory at (start_ptr + rd_addr) mod SAMPLE_DEPTH; rd_data valid the cycle after rd_addr; reads before CAPTURED return stale contents, no error.

Reset
REQ-027 rst SHALL force state IDLE, done 0, pointers/counters/start_ptr 0, p_q/p_qq 0, asynchronously.
REQ-028 Memory contents SHALL NOT be reset; rd_data after reset undefined until first read.
REQ-029 Reset mid-capture SHALL abandon the capture; no partial-state retention.

Structure
REQ-030 Package la_pkg SHALL hold the state enum and trigger-mode enum.
REQ-031 Sample storage SHALL be sub-module la_sample_mem: simple dual-port RAM, one write port, one registered read port, inferable as block RAM.

Verification (WIDTH=8, DEPTH=16, LOC=4)
REQ-032 Counter on probes, EQ mask FF value 0x20, arm at count 0x10 -> CAPTURED; rd_addr 0..15 returns 0x1C..0x2B, rd_addr 4 = 0x20.
REQ-033 RISING mask 0x01 on bit0 toggling every 8 cycles -> triggering sample at index 4 has bit0=1, index 3 bit0=0.
REQ-034 Trigger condition true during MOVE_TO_POS only -> stays IN_POSITION, no capture; done 0.
REQ-035 LOC=0 build, CHANGE mask 0xFF with constant probes then one step -> trigger sample at index 0, 16 samples stored.
REQ-036 arm while CAPTURING -> state MOVE_TO_POS next cycle, done 0; rst asserted mid-IN_POSITION -> state 0 immediately, done 0.
REQ-037 Trigger delayed >3*DEPTH cycles (pointer wrapped) -> readback still oldest-first contiguous, index 4 = trigger sample.
